// File: rtl/uart_cmd_parser.sv
// Assembles UART byte frames (header, opcode, address, optional write data) into a
// single SDRAM read/write request with req/ack handshake, plus timeout/overrun reporting.
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1_330_000,
  parameter int unsigned CNT_WIDTH   = 21
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        po_flag,
  output logic        cmd_wr_req,
  output logic        cmd_rd_req,
  output logic [15:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  input  logic        cmd_ack,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR_H = 3'd2;
  localparam logic [2:0] S_ADDR_L = 3'd3;
  localparam logic [2:0] S_DATA_H = 3'd4;
  localparam logic [2:0] S_DATA_L = 3'd5;
  localparam logic [2:0] S_ISSUE  = 3'd6;

  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYC - 1);

  logic [2:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_op_rd;
  logic                 w_timeout;

  assign w_timeout = (r_cnt == CNT_LAST);
  assign busy      = (r_state != S_IDLE);

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op_rd    <= 1'b0;
      cmd_wr_req <= 1'b0;
      cmd_rd_req <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (po_flag && rx_data == HEADER) r_state <= S_CMD;
        end
        S_ISSUE: begin
          r_cnt <= '0;
          if (cmd_ack) begin
            cmd_wr_req <= 1'b0;
            cmd_rd_req <= 1'b0;
            r_state    <= S_IDLE;
          end
          if (po_flag) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
        end
        S_CMD, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L: begin
          // An arriving byte takes priority over a timeout on the same edge.
          if (po_flag) begin
            r_cnt <= '0;
            case (r_state)
              S_CMD: begin
                if (rx_data == OP_WR) begin
                  r_op_rd <= 1'b0;
                  r_state <= S_ADDR_H;
                end else if (rx_data == OP_RD) begin
                  r_op_rd <= 1'b1;
                  r_state <= S_ADDR_H;
                end else begin
                  r_state   <= S_IDLE;
                  frame_err <= 1'b1;
                  err_code  <= ERR_OPCODE;
                end
              end
              S_ADDR_H: begin
                cmd_addr[15:8] <= rx_data;
                r_state        <= S_ADDR_L;
              end
              S_ADDR_L: begin
                cmd_addr[7:0] <= rx_data;
                if (r_op_rd) begin
                  cmd_rd_req <= 1'b1;
                  r_state    <= S_ISSUE;
                end else begin
                  r_state <= S_DATA_H;
                end
              end
              S_DATA_H: begin
                cmd_wdata[15:8] <= rx_data;
                r_state         <= S_DATA_L;
              end
              default: begin
                cmd_wdata[7:0] <= rx_data;
                cmd_wr_req     <= 1'b1;
                r_state        <= S_ISSUE;
              end
            endcase
          end else if (w_timeout) begin
            r_cnt     <= '0;
            r_state   <= S_IDLE;
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Sequencer between the UART receiver and the SDRAM controller's command port. Consumes the byte stream (rx_data qualified by the one-cycle po_flag pulse) and assembles framed commands: header, opcode, 16-bit address, and 16-bit write data for writes only. It then issues a single write or read request with a req/ack handshake. It also reports malformed frames, inter-byte timeouts and overruns.

Parameters:
HEADER, 8'hA5, frame start byte
TIMEOUT_CYC, 1_330_000, max sys_clk cycles between bytes inside a frame (10 ms at 133 MHz)
CNT_WIDTH, 21, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYC

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  reset, asynchronous, active-high
rx_data  in  8  received byte, valid only when po_flag=1
po_flag  in  1  one-cycle byte-valid pulse from UART receiver
cmd_wr_req  out  1  write request to SDRAM controller, held until ack
cmd_rd_req  out  1  read request to SDRAM controller, held until ack
cmd_addr  out  16  request address {addr_hi, addr_lo}, stable while req high
cmd_wdata  out  16  write data {data_hi, data_lo}, stable while cmd_wr_req high
cmd_ack  in  1  SDRAM controller accepts request (sampled on rising edge)
frame_err  out  1  one-cycle error pulse
err_code  out  2  last error: 0 none, 1 bad opcode, 2 timeout, 3 overrun
busy  out  1  1 whenever state != IDLE

Behaviour:
- Design has one clock; reset is asynchronous and active-high.
- Reset: state=IDLE; all outputs 0; cmd_addr, cmd_wdata, timeout counter and opcode register cleared. Asserting reset in any state, including ISSUE, drops the request immediately.
- Byte accept: a byte is accepted on the rising edge where po_flag=1.
- State transitions on accepted bytes:
  - IDLE: byte==HEADER -> CMD. Any other byte is ignored, with no error.
  - CMD: 8'h01 -> ADDR_H, op=write. 8'h02 -> ADDR_H, op=read. Any other byte -> IDLE with error code 1.
  - ADDR_H: latch cmd_addr[15:8] -> ADDR_L.
  - ADDR_L: latch cmd_addr[7:0]. If op=read -> ISSUE. If op=write -> DATA_H.
  - DATA_H: latch cmd_wdata[15:8] -> DATA_L.
  - DATA_L: latch cmd_wdata[7:0] -> ISSUE.
- Request timing: the request is registered.
  - The edge that accepts the final byte also sets cmd_wr_req or cmd_rd_req to 1, so req is high in the cycle after the last po_flag.
  - Only one of the two req outputs is ever high.
- Handshake:
  - ISSUE holds req, cmd_addr and cmd_wdata constant until an edge samples cmd_ack=1.
  - On that edge req<=0 and state<=IDLE, so req falls the cycle after ack.
  - Ack sampled on the first ISSUE cycle is legal, giving a 1-cycle request.
  - cmd_ack outside ISSUE is ignored.
- Timeout:
  - The counter clears in IDLE and ISSUE, and on every accepted byte.
  - Otherwise it increments each cycle in CMD..DATA_L.
  - When the counter equals TIMEOUT_CYC-1 with no byte that cycle: state -> IDLE, error code 2, partial frame discarded.
  - A po_flag on the same edge as the timeout wins: the byte is accepted and the counter cleared.
  - ISSUE has no timeout; it waits indefinitely for ack.
- Overrun: po_flag while in ISSUE drops the byte and raises error code 3. State, req and latched fields are unchanged. If ack and po_flag coincide, both take effect: IDLE, the byte is dropped, error 3.
- Error reporting: on each error frame_err=1 for exactly one cycle and err_code is loaded. err_code holds until the next error or reset.
- busy is combinational from state: 1 in CMD..ISSUE.
- Back-to-back frames: a HEADER byte arriving the cycle after leaving ISSUE is accepted normally.

Test Plan:
- Write frame A5,01,12,34,BE,EF; ack 3 cycles after req rises -> cmd_wr_req=1 for 3 cycles, starting 1 cycle after the 6th po_flag; cmd_addr=16'h1234; cmd_wdata=16'hBEEF; cmd_rd_req=0; busy returns 0 the cycle after ack; no frame_err.
- Read frame A5,02,00,40 with ack tied high -> cmd_rd_req pulses exactly 1 cycle, cmd_addr=16'h0040; preceding stray bytes 00,FF are ignored with no error.
- A5,07 -> frame_err pulse, err_code=1, state IDLE. A following A5,02,AB,CD still yields a read at 16'hABCD.
- TIMEOUT_CYC=50: A5,01,12 then silence -> frame_err and err_code=2 exactly 50 cycles after the last po_flag, busy=0. Repeat with a byte landing exactly on cycle 50 -> no timeout, frame continues.
- Hold ack low in ISSUE and send byte 55 -> frame_err, err_code=3, req stays high, cmd_addr/cmd_wdata unchanged. Assert sys_rst mid-ISSUE -> req drops immediately, all outputs return to 0.
